// File: rtl/lfsr_if.sv
// lfsr_if: LFSR control/status bundle; master drives load/din/en/mode, slave returns q/serial_out/lockup/wrap/count/period
interface lfsr_if #(parameter int WIDTH = 26);
  logic load;
  logic en;
  logic mode;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] period;
  logic serial_out;
  logic lockup;
  logic wrap;
  modport master(output load, en, mode, din, input q, count, period, serial_out, lockup, wrap);
  modport slave(input load, en, mode, din, output q, count, period, serial_out, lockup, wrap);
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci/Galois LFSR with load, lockup detect and period monitor; ports clk, rst (async high), lfsr_if.slave b; LFSR_LOCKUP_RECOVER_EN reseeds from all-zero on step
module lfsr_gen #(
  parameter int WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS = 26'h2000023,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic clk,
  input logic rst,
  lfsr_if.slave b
);
  logic [WIDTH-1:0] q, r, cnt, per, nq, fib, gal, inc;
  logic w, hit, zero;
  assign fib = {q[WIDTH-2:0], ^(q & TAPS)};
  assign gal = {q[WIDTH-2:0], q[WIDTH-1]} ^ ({WIDTH{q[WIDTH-1]}} & {TAPS[WIDTH-2:0], 1'b0});
  assign nq = b.mode ? gal : fib;
  assign hit = nq == r;
  assign zero = q == '0;
  assign inc = cnt + WIDTH'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= SEED;
      r <= SEED;
      cnt <= '0;
      per <= '0;
      w <= 1'b0;
    end else if (b.load) begin
      q <= b.din;
      r <= b.din;
      cnt <= '0;
      w <= 1'b0;
    end else if (b.en && !zero) begin
      q <= nq;
      w <= hit;
      cnt <= hit ? '0 : inc;
      if (hit) per <= inc;
    end
`ifdef LFSR_LOCKUP_RECOVER_EN
    else if (b.en) begin
      q <= SEED;
      r <= SEED;
      cnt <= '0;
      w <= 1'b0;
    end
`endif
    else w <= 1'b0;
  assign b.q = q;
  assign b.serial_out = q[WIDTH-1];
  assign b.lockup = zero;
  assign b.wrap = w;
  assign b.count = cnt;
  assign b.period = per;
endmodule
